psum_pingpong_acc: RTL and testbench

- Parametrised partial-sum accumulator for the CU output path.
- Sums NUM_PE signed PE lanes with a stored psum on every accepted beat, over a tile of cfg_len entries accumulated across multiple input-channel passes.
- Two internal banks work in ping-pong: one accumulates while the other drains finished sums downstream under valid/ready backpressure.
- Replaces fixed 3-lane, FIFO-status-driven accumulation with explicit address counters, per-bank state machines and handshakes.

---
 rtl/psum_pingpong_acc.sv | 162 ++++++++++++++++
 tb/tb_psum_pingpong_acc.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_pingpong_acc.sv
// Ping-pong partial-sum accumulator: NUM_PE lanes plus stored psum per beat.
// Define PSUM_SAT_EN to saturate each write-back instead of wrapping.
module psum_pingpong_acc #(
   parameter int DWIDTH = 32,
   parameter int NUM_PE = 3,
   parameter int DEPTH  = 16,
   parameter int AWIDTH = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [AWIDTH:0]          cfg_len,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_first,
   input  logic                     in_last,
   input  logic [NUM_PE*DWIDTH-1:0] pe_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DWIDTH-1:0]        out_data,
   output logic                     out_last
);

`ifdef PSUM_SAT_EN
   localparam int WW = DWIDTH + $clog2(NUM_PE + 1);
`else
   localparam int WW = DWIDTH;
`endif
   localparam logic [AWIDTH:0]   DEPTH_L = (AWIDTH + 1)'(DEPTH);
   localparam logic [AWIDTH:0]   LEN1    = (AWIDTH + 1)'(1);
   localparam logic [AWIDTH-1:0] ADDR1   = AWIDTH'(1);

   typedef enum logic [1:0] {
      FREE  = 2'd0,
      ACC   = 2'd1,
      DRAIN = 2'd2
   } bank_st_t;

   bank_st_t          st    [2];
   logic [AWIDTH:0]   len_q [2];
   logic [DWIDTH-1:0] mem   [2][DEPTH];

   logic              fill_sel;
   logic              drain_sel;
   logic [AWIDTH-1:0] wr_addr;
   logic [AWIDTH-1:0] rd_addr;
   logic              issued;

   logic                     s2_valid;
   logic                     s2_done;
   logic                     s2_bank;
   logic                     s2_first;
   logic [AWIDTH-1:0]        s2_addr;
   logic [NUM_PE*DWIDTH-1:0] s2_lanes;
   logic [DWIDTH-1:0]        s2_rd;

   logic [AWIDTH:0]   cfg_eff;
   logic [AWIDTH:0]   len_cur;
   logic              accept;
   logic              pass_end;
   logic              byp_hit;
   logic [WW-1:0]     wide;
   logic [DWIDTH-1:0] wr_val;
   logic              load;
   logic              load_last;
   logic              out_done;

   always_comb begin
      cfg_eff = cfg_len;
      if (cfg_len == '0 || cfg_len > DEPTH_L)
         cfg_eff = DEPTH_L;
      len_cur  = (st[fill_sel] == FREE) ? cfg_eff : len_q[fill_sel];
      in_ready = !rst && (st[fill_sel] != DRAIN);
      accept   = in_valid && in_ready;
      pass_end = ({1'b0, wr_addr} == len_cur - LEN1);
      byp_hit  = s2_valid && (s2_bank == fill_sel) && (s2_addr == wr_addr);
   end

   always_comb begin
      wide = s2_first ? '0 : WW'($signed(s2_rd));
      for (int k = 0; k < NUM_PE; k++)
         wide = wide + WW'($signed(s2_lanes[k*DWIDTH +: DWIDTH]));
`ifdef PSUM_SAT_EN
      if (wide[WW-1:DWIDTH-1] == '0 || wide[WW-1:DWIDTH-1] == '1)
         wr_val = wide[DWIDTH-1:0];
      else if (wide[WW-1])
         wr_val = {1'b1, {(DWIDTH-1){1'b0}}};
      else
         wr_val = {1'b0, {(DWIDTH-1){1'b1}}};
`else
      wr_val = wide[DWIDTH-1:0];
`endif
   end

   always_comb begin
      out_done  = out_valid && out_ready && out_last;
      load      = (st[drain_sel] == DRAIN) && !issued &&
                  (!out_valid || out_ready);
      load_last = ({1'b0, rd_addr} == len_q[drain_sel] - LEN1);
   end

   // Stage-1 read forwards the in-flight sum when it targets the same entry.
   always_ff @(posedge clk) begin
      if (accept) begin
         s2_bank  <= fill_sel;
         s2_addr  <= wr_addr;
         s2_first <= in_first;
         s2_lanes <= pe_data;
         s2_rd    <= byp_hit ? wr_val : mem[fill_sel][wr_addr];
      end
      if (s2_valid)
         mem[s2_bank][s2_addr] <= wr_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st[0]     <= FREE;
         st[1]     <= FREE;
         len_q[0]  <= '0;
         len_q[1]  <= '0;
         fill_sel  <= 1'b0;
         drain_sel <= 1'b0;
         wr_addr   <= '0;
         rd_addr   <= '0;
         issued    <= 1'b0;
         s2_valid  <= 1'b0;
         s2_done   <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         s2_valid <= accept;
         s2_done  <= accept && pass_end && in_last;
         if (accept) begin
            if (st[fill_sel] == FREE) begin
               st[fill_sel]    <= ACC;
               len_q[fill_sel] <= cfg_eff;
            end
            wr_addr <= pass_end ? '0 : wr_addr + ADDR1;
            if (pass_end && in_last)
               fill_sel <= ~fill_sel;
         end
         if (s2_done)
            st[s2_bank] <= DRAIN;
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= mem[drain_sel][rd_addr];
            out_last  <= load_last;
            rd_addr   <= load_last ? '0 : rd_addr + ADDR1;
            issued    <= load_last;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         if (out_done) begin
            st[drain_sel] <= FREE;
            drain_sel     <= ~drain_sel;
            issued        <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_psum_pingpong_acc.sv
// Bench for psum_pingpong_acc: table vectors, corner sequences, random tiles.
// Expected sums come from a per-entry arithmetic model of the pass rules.
module tb_psum_pingpong_acc;

   localparam int DW = 32;
   localparam int NP = 3;
   localparam int AW = 4;

`ifdef PSUM_SAT_EN
   localparam logic [31:0] SAT_A = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_B = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_C = 32'h8000_0000;
`else
   localparam logic [31:0] SAT_A = 32'h8000_0000;
   localparam logic [31:0] SAT_B = 32'hFFFF_FFFE;
   localparam logic [31:0] SAT_C = 32'h7FFF_FFFF;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [AW:0]      cfg_len;
   logic             in_valid;
   logic             in_ready;
   logic             in_first;
   logic             in_last;
   logic [NP*DW-1:0] pe_data;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_data;
   logic             out_last;

   always #5 clk = ~clk;

   psum_pingpong_acc dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_len   (cfg_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_first  (in_first),
      .in_last   (in_last),
      .pe_data   (pe_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   typedef struct {
      logic [31:0] d;
      logic        l;
   } exp_t;

   typedef struct {
      int          len;
      int          np;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] expv;
   } vec_t;

   int          total = 0;
   int          bad = 0;
   exp_t        exp_q[$];
   logic [31:0] td [4][16][3];
   bit          rdy_rand = 0;
   bit          scramble = 0;
   vec_t        vt [8];
   bit          pat [4];

   function automatic logic [31:0] fold(input longint v);
`ifdef PSUM_SAT_EN
      if (v > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
      if (v < -64'sh8000_0000) return 32'h8000_0000;
`endif
      return v[31:0];
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, want);
      end
   endtask

   // Output monitor: scoreboard compare plus hold-stability under backpressure.
   initial begin
      logic        pv;
      logic [31:0] pd;
      logic        pl;
      exp_t        e;
      pv = 1'b0;
      pd = '0;
      pl = 1'b0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            pv = 1'b0;
         end else begin
            if (pv) begin
               check("hold_valid", 32'(out_valid), 32'd1);
               check("hold_data", out_data, pd);
               check("hold_last", 32'(out_last), 32'(pl));
            end
            pv = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL extra_out got=%h want=none", out_data);
               end else begin
                  e = exp_q.pop_front();
                  check("out_data", out_data, e.d);
                  check("out_last", 32'(out_last), 32'(e.l));
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic set_rdy(input logic v);
      @(posedge clk);
      #1;
      out_ready = v;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic beat(input logic f, input logic l,
                       input logic [NP*DW-1:0] d);
      int n;
      n = 0;
      @(posedge clk);
      #1;
      if (scramble) cfg_len = 5'($urandom);
      in_valid = 1'b1;
      in_first = f;
      in_last  = l;
      pe_data  = d;
      @(negedge clk);
      while (!in_ready) begin
         n++;
         if (n > 2000) begin
            total++;
            bad++;
            $display("FAIL in_ready_wait got=0 want=1");
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic tile(input int len, input int np, input bit gap,
                       input bit use_tab, input logic [31:0] texp);
      logic [31:0] acc [16];
      longint      s;
      exp_t        e;
      for (int i = 0; i < len; i++) begin
         acc[i] = '0;
         for (int p = 0; p < np; p++) begin
            s = (p == 0) ? 64'sd0 : longint'($signed(acc[i]));
            for (int k = 0; k < NP; k++)
               s = s + longint'($signed(td[p][i][k]));
            acc[i] = fold(s);
         end
         e.d = use_tab ? texp : acc[i];
         e.l = (i == len - 1);
         exp_q.push_back(e);
      end
      cfg_len = (len == 16) ? 5'd0 : 5'(len);
      for (int p = 0; p < np; p++) begin
         for (int i = 0; i < len; i++) begin
            if (gap && $urandom_range(0, 3) == 0) idle();
            scramble = !(p == 0 && i == 0);
            beat(p == 0, p == np - 1, {td[p][i][2], td[p][i][1], td[p][i][0]});
         end
      end
      scramble = 0;
   endtask

   task automatic fill_const(input int np, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] c);
      for (int p = 0; p < np; p++)
         for (int i = 0; i < 16; i++) begin
            td[p][i][0] = a;
            td[p][i][1] = b;
            td[p][i][2] = c;
         end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      vt[0] = '{4,  1, 32'd1,         32'd2,         32'd3, 32'd6};
      vt[1] = '{1,  3, 32'd1,         32'd1,         32'd1, 32'd9};
      vt[2] = '{2,  2, 32'hFFFF_FFFB, 32'd3,         32'd1, 32'hFFFF_FFFE};
      vt[3] = '{16, 1, 32'd7,         32'd0,         32'd0, 32'd7};
      vt[4] = '{3,  4, 32'd100,       32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd392};
      vt[5] = '{1,  1, 32'h7FFF_FFFF, 32'd1,         32'd0, SAT_A};
      vt[6] = '{1,  2, 32'h7FFF_FFFF, 32'd0,         32'd0, SAT_B};
      vt[7] = '{1,  1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SAT_C};
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};

      rst       = 1'b1;
      cfg_len   = '0;
      in_valid  = 1'b0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      pe_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      check("post_rst_out_data", out_data, 32'd0);
      check("post_rst_out_last", 32'(out_last), 32'd0);

      for (int v = 0; v < 8; v++) begin
         fill_const(vt[v].np, vt[v].a, vt[v].b, vt[v].c);
         tile(vt[v].len, vt[v].np, 1'b0, 1'b1, vt[v].expv);
         idle();
         drain();
      end

      fill_const(1, 32'd1, 32'd2, 32'd3);
      for (int i = 0; i < 4; i++) begin
         td[1][i][0] = 32'd10;
         td[1][i][1] = 32'd20;
         td[1][i][2] = 32'd30;
      end
      tile(4, 2, 1'b0, 1'b1, 32'd66);
      idle();
      drain();
      @(negedge clk);
      check("free_after_drain_in_ready", 32'(in_ready), 32'd1);

      set_rdy(1'b0);
      fill_const(1, 32'd1, 32'd1, 32'd1);
      tile(2, 1, 1'b0, 1'b1, 32'd3);
      fill_const(1, 32'd2, 32'd2, 32'd2);
      tile(2, 1, 1'b0, 1'b1, 32'd6);
      idle();
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", out_data, 32'd3);
      set_rdy(1'b1);
      begin
         int n;
         n = 0;
         @(negedge clk);
         while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("bp_in_ready_back", 32'(in_ready), 32'd1);
      end
      drain();

      set_rdy(1'b0);
      for (int i = 0; i < 4; i++) begin
         td[0][i][0] = 32'(i * 5 + 1);
         td[0][i][1] = 32'd0;
         td[0][i][2] = 32'd0;
      end
      tile(4, 1, 1'b0, 1'b0, 32'd0);
      idle();
      begin
         int n;
         n = 0;
         @(negedge clk);
         while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("tog_out_valid", 32'(out_valid), 32'd1);
      end
      for (int i = 0; i < 4; i++) set_rdy(pat[i]);
      set_rdy(1'b1);
      drain();

      fill_const(1, 32'd9, 32'd9, 32'd9);
      cfg_len = 5'd4;
      beat(1'b1, 1'b0, {32'd9, 32'd9, 32'd9});
      beat(1'b1, 1'b0, {32'd9, 32'd9, 32'd9});
      @(posedge clk);
      #1;
      rst      = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_ready_back", 32'(in_ready), 32'd1);
      check("mid_rst_out_data", out_data, 32'd0);
      td[0][0][0] = 32'd4;
      td[0][0][1] = 32'hFFFF_FFFF;
      td[0][0][2] = 32'd2;
      td[0][1][0] = 32'd100;
      td[0][1][1] = 32'd200;
      td[0][1][2] = 32'd300;
      tile(2, 1, 1'b0, 1'b0, 32'd0);
      idle();
      drain();

      rdy_rand = 1;
      for (int t = 0; t < 14; t++) begin
         int len;
         int np;
         len = $urandom_range(1, 16);
         np  = $urandom_range(1, 3);
         for (int p = 0; p < np; p++)
            for (int i = 0; i < len; i++)
               for (int k = 0; k < NP; k++)
                  td[p][i][k] = (t % 2 == 0) ? $urandom :
                                32'($urandom_range(0, 40)) - 32'd20;
         tile(len, np, 1'b1, 1'b0, 32'd0);
      end
      idle();
      drain();
      rdy_rand = 0;
      set_rdy(1'b1);
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
